// File: rtl/irda_mode_ctrl.sv
// irda_mode_ctrl: IrDA mode register with shadow/active copies and link-safe critical switching
//
// A host writes the master (shadow) register at any time. Non-critical bits
// (LB, reserved, DMA) reach the active register one cycle later. Critical bits
// (SPEED [4:3], MODE [1]) are only copied into the active register while the
// IrDA link is idle. Each such copy is followed by a transceiver settle window.
//
// Ports
//   clk              single rising-edge clock
//   wb_rst_i         synchronous active-high reset
//   wb_addr_i        register address (MASTER_ADDR / STATUS_ADDR)
//   wb_dat_i         write data
//   we_i             write strobe, one write per cycle
//   link_busy_i      frame in progress on the link
//   wb_dat_o         combinational read data
//   master           active register bits [7:1]
//   fast_mode        active speed != SIR
//   mir_mode         active[4]
//   mir_half         active speed == MIR half
//   fir_mode         active speed == FIR
//   tx_select        active[1]
//   loopback_enable  active[2]
//   use_dma          active[7]
//   pending_o        critical change waiting for an idle link
//   switching_o      settle window active
//   mode_change_o    one-cycle pulse after critical bits are applied
module irda_mode_ctrl #(
    parameter int                ADDR_W        = 4,
    parameter logic [ADDR_W-1:0] MASTER_ADDR   = '0,
    parameter logic [ADDR_W-1:0] STATUS_ADDR   = ADDR_W'(1),
    parameter logic [7:1]        RESET_VAL     = 7'h00,
    parameter int                SETTLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [7:0]        wb_dat_i,
    input  logic              we_i,
    input  logic              link_busy_i,
    output logic [7:0]        wb_dat_o,
    output logic [7:1]        master,
    output logic              fast_mode,
    output logic              mir_mode,
    output logic              mir_half,
    output logic              fir_mode,
    output logic              tx_select,
    output logic              loopback_enable,
    output logic              use_dma,
    output logic              pending_o,
    output logic              switching_o,
    output logic              mode_change_o
);
    // SPEED [4:3] and MODE [1]
    localparam logic [7:1] CRIT = 7'b0001101;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PEND, SETTLE} state_t;

    state_t     state_q, state_d;
    logic [7:1] shadow_q, shadow_d;
    logic [7:1] active_q, active_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pulse_q, pulse_d;
    logic       crit_diff, apply, restore, wr_master, abort;

    assign wr_master = we_i && wb_addr_i == MASTER_ADDR;
    assign abort     = we_i && wb_addr_i == STATUS_ADDR && wb_dat_i[0];
    assign crit_diff = |((shadow_q ^ active_q) & CRIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        apply   = 1'b0;
        restore = 1'b0;
        case (state_q)
            IDLE: begin
                if (crit_diff) begin
                    if (link_busy_i) state_d = PEND;
                    else             apply   = 1'b1;
                end
            end
            PEND: begin
                // abort takes priority over an apply in the same cycle
                if (abort) begin
                    restore = 1'b1;
                    state_d = IDLE;
                end else if (!crit_diff) begin
                    state_d = IDLE;
                end else if (!link_busy_i) begin
                    apply = 1'b1;
                end
            end
            SETTLE: begin
                // counter holds remaining cycles minus one; leave on zero
                if (cnt_q == 8'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
        if (apply) begin
            state_d = (SETTLE_CYCLES == 0) ? IDLE : SETTLE;
            cnt_d   = SETTLE_LAST;
        end
    end

    // apply and the shadow write use the pre-edge shadow, so a write in the
    // apply cycle is seen only by the following evaluation
    assign pulse_d  = apply;
    assign shadow_d = wr_master ? wb_dat_i[7:1] :
                      restore   ? (shadow_q & ~CRIT) | (active_q & CRIT) : shadow_q;
    assign active_d = (shadow_q & ~CRIT) | ((apply ? shadow_q : active_q) & CRIT);

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            shadow_q <= RESET_VAL;
            active_q <= RESET_VAL;
            cnt_q    <= 8'd0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pending_o       = state_q == PEND;
    assign switching_o     = state_q == SETTLE;
    assign mode_change_o   = pulse_q;
    assign master          = active_q;
    assign fast_mode       = |active_q[4:3];
    assign mir_mode        = active_q[4];
    assign mir_half        = active_q[4:3] == 2'b10;
    assign fir_mode        = active_q[4:3] == 2'b01;
    assign tx_select       = active_q[1];
    assign loopback_enable = active_q[2];
    assign use_dma         = active_q[7];

    assign wb_dat_o = (wb_addr_i == MASTER_ADDR) ? {shadow_q, 1'b0} :
                      (wb_addr_i == STATUS_ADDR) ? {6'b0, switching_o, pending_o} : 8'h00;
endmodule

// File: doc/irda_mode_ctrl.md
IRDA_MODE_CTRL -- requirements
Module: irda_mode_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 4, register address width.
- MASTER_ADDR, 0, address of the master (shadow) register.
- STATUS_ADDR, 1, address of the status/abort register.
- RESET_VAL, 7'h00, reset value of the shadow and active registers, bits [7:1].
- SETTLE_CYCLES, 16, transceiver settle time after a critical change; legal range 0..255.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state is updated on its rising edge.
- wb_rst_i, in, 1, reset; synchronous and active-high.
- wb_addr_i, in, ADDR_W, register address.
- wb_dat_i, in, 8, write data.
- we_i, in, 1, write strobe; one write per cycle.
- link_busy_i, in, 1, frame in progress on the IrDA link.
- wb_dat_o, out, 8, combinational read data.
- master, out, 7 ([7:1]), active register.
- fast_mode, out, 1, active speed != 00.
- mir_mode, out, 1, active[4].
- mir_half, out, 1, active speed == 10.
- fir_mode, out, 1, active speed == 01.
- tx_select, out, 1, active[1].
- loopback_enable, out, 1, active[2].
- use_dma, out, 1, active[7].
- pending_o, out, 1, a critical change is waiting for the link to go idle.
- switching_o, out, 1, settle window is active.
- mode_change_o, out, 1, one-cycle pulse when critical bits are applied.

Function
REQ-003 Bit map: [1] MODE (tx), [2] LB, [4:3] SPEED (00 SIR, 01 FIR, 10 MIR half, 11 MIR full), [6:5] reserved (stored), [7] DMA.
REQ-004 Critical bits are [4:3] and [1]; all other bits are non-critical.
REQ-005 When we_i=1 and wb_addr_i==MASTER_ADDR, shadow <= wb_dat_i[7:1] at the next edge; wb_dat_i[0] is ignored.
REQ-006 Non-critical bits of active follow shadow with one cycle of lag, in every FSM state, so outputs reflect a write at the 2nd edge after we_i.
REQ-007 The FSM has three states: IDLE, PEND and SETTLE; its reset state is IDLE.
REQ-008 IDLE, critical bits of shadow != active, link_busy_i=0: at that edge copy the critical bits into active, pulse mode_change_o, and go to SETTLE (or stay in IDLE if SETTLE_CYCLES==0).
REQ-009 IDLE, critical bits differ, link_busy_i=1: go to PEND; pending_o=1 while in PEND.
REQ-010 PEND, critical bits still differ, link_busy_i=0: apply exactly as in REQ-008.
REQ-011 PEND, shadow critical bits rewritten equal to active: return to IDLE with no pulse and no settle.
REQ-012 SETTLE: switching_o=1 for exactly SETTLE_CYCLES cycles, counted from the edge after apply, then go to IDLE.
REQ-013 SETTLE: link_busy_i is ignored; writes update shadow; a new critical difference is evaluated only after the return to IDLE.
REQ-014 Abort: a write to STATUS_ADDR with wb_dat_i[0]=1 while in PEND restores the shadow critical bits from active and returns to IDLE with no pulse.
REQ-015 Abort in IDLE or SETTLE has no effect.
REQ-016 A write to any other address has no effect.
REQ-017 Read data:
- wb_dat_o = {shadow,1'b0} when wb_addr_i==MASTER_ADDR;
- wb_dat_o = {6'b0, switching_o, pending_o} when wb_addr_i==STATUS_ADDR;
- wb_dat_o = 0 at any other address.
REQ-018 All decoded mode outputs are combinational functions of active only, never of shadow.

Reset
REQ-019 With wb_rst_i=1 at an edge: shadow=active=RESET_VAL, FSM=IDLE, counter=0, and pending_o, switching_o, mode_change_o=0.
REQ-020 Reset overrides a coincident write and takes effect mid-PEND or mid-SETTLE.
REQ-021 Decoded outputs after reset follow RESET_VAL (default: all 0, SIR, rx).

Verification
REQ-022 Write 0x08 (FIR) with link_busy_i=0 -> fir_mode=1 and a single mode_change_o pulse at the 2nd edge; switching_o=1 for 16 cycles, then 0.
REQ-023 link_busy_i=1, write 0x10 -> pending_o=1 and active speed unchanged for 50 cycles; drop busy -> mir_half=1 and one pulse at the next edge.
REQ-024 In PEND, write STATUS 0x01 -> pending_o=0, no pulse, and MASTER reads back the old critical bits.
REQ-025 link_busy_i=1, write 0x84 -> use_dma=1 and loopback_enable=1 at the 2nd edge, with pending_o=0.
REQ-026 During SETTLE, write 0x18 -> no apply before switching_o falls; applied at the 1st edge in IDLE.
REQ-027 Assert wb_rst_i mid-SETTLE -> all outputs match RESET_VAL at the next edge; switching_o=0.
